// File: rtl/c5_mem_arbiter.sv
// Two-master arbiter for the c5 memory port: the CPU owns the bus by default and
// master 1 borrows it for one access by pausing the CPU, after a minimum CPU run.
module c5_mem_arbiter #(
    parameter int CPU_SLOTS = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:2] I_cpu_address,
    input  logic [3:0]  I_cpu_byte_we,
    input  logic [31:0] I_cpu_data_w,
    output logic [31:0] O_cpu_data_r,
    output logic        O_cpu_pause,
    input  logic        I_m1_req,
    input  logic [31:2] I_m1_address,
    input  logic [3:0]  I_m1_byte_we,
    input  logic [31:0] I_m1_data_w,
    output logic        O_m1_ack,
    output logic [31:0] O_m1_data_r,
    output logic        O_m1_grant,
    output logic [31:2] O_mem_address,
    output logic [3:0]  O_mem_byte_we,
    output logic [31:0] O_mem_data_w,
    input  logic [31:0] I_mem_data_r,
    input  logic        I_mem_pause
);

    localparam int CNT_W = (CPU_SLOTS < 1) ? 1 : $clog2(CPU_SLOTS + 1);
    localparam logic [CNT_W-1:0] SLOT_MAX = CNT_W'(CPU_SLOTS);

    typedef enum logic [1:0] {
        S_CPU,
        S_M1_ADDR,
        S_M1_DATA
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= S_CPU;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // The counter only saturates upward, so equality with SLOT_MAX means the CPU run is long enough.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        O_mem_address = I_cpu_address;
        O_mem_byte_we = I_cpu_byte_we;
        O_mem_data_w  = I_cpu_data_w;
        O_cpu_pause   = I_mem_pause;
        O_m1_grant    = 1'b0;
        O_m1_ack      = 1'b0;
        case (r_state)
            S_CPU: begin
                if (!I_mem_pause) begin
                    if (r_cnt != SLOT_MAX) begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                    if (I_m1_req && (r_cnt == SLOT_MAX)) begin
                        w_stateNext = S_M1_ADDR;
                    end
                end
            end
            S_M1_ADDR: begin
                O_mem_address = I_m1_address;
                O_mem_byte_we = I_m1_byte_we;
                O_mem_data_w  = I_m1_data_w;
                O_cpu_pause   = 1'b1;
                O_m1_grant    = 1'b1;
                if (!I_mem_pause) begin
                    w_stateNext = S_M1_DATA;
                end
            end
            S_M1_DATA: begin
                // Re-present the stalled CPU access as a read so nothing is written twice.
                O_mem_byte_we = 4'b0000;
                O_cpu_pause   = 1'b1;
                O_m1_grant    = 1'b1;
                O_m1_ack      = 1'b1;
                w_stateNext   = S_CPU;
                w_cntNext     = '0;
            end
            default: begin
                w_stateNext = S_CPU;
                w_cntNext   = '0;
            end
        endcase
    end

    assign O_cpu_data_r = I_mem_data_r;
    assign O_m1_data_r  = I_mem_data_r;

endmodule
